// File: rtl/clk_div_pkg.sv
// Shared definitions for the run-time clock divider controller.
// Contents:
//   DIV_W   - default datapath width for ratios and counters
//   DIV_MIN - smallest legal divide ratio
//   state_e - controller FSM encoding
package clk_div_pkg;

    localparam int unsigned DIV_W   = 32;
    localparam int unsigned DIV_MIN = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio configuration channel for clk_div_ctrl.
// Signals:
//   cfg_n     - requested divide ratio (master -> slave)
//   cfg_valid - cfg_n valid this cycle (master -> slave)
//   cfg_ready - slave can take a ratio this cycle (slave -> master)
//   cfg_err   - one-cycle pulse, last accepted ratio was illegal (slave -> master)
interface clk_div_ctrl_if
    import clk_div_pkg::*;
#(
    parameter int unsigned W = DIV_W
);
    logic [W-1:0] cfg_n;
    logic         cfg_valid;
    logic         cfg_ready;
    logic         cfg_err;

    modport master (
        output cfg_n,
        output cfg_valid,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_n,
        input  cfg_valid,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_core.sv
// Divider datapath: period counter, high-phase compare and registered outputs.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   start_i       - begin the first period next cycle (from IDLE)
//   active_i      - counter is running (RUN or STOP)
//   restart_i     - at a boundary, begin a new period; otherwise drain to idle
//   cur_n_i       - ratio in effect for the current period
//   boundary_o    - last cycle of the current period
//   clk_out_o     - registered divided clock
//   tick_o        - one-cycle pulse with each clk_out_o rising edge
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         active_i,
    input  logic         restart_i,
    input  logic [W-1:0] cur_n_i,
    output logic         boundary_o,
    output logic         clk_out_o,
    output logic         tick_o
);

    logic [W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [W:0]   half;
    logic         clk_out_q, clk_out_d;
    logic         tick_q, tick_d;

    // One extra bit so that (N+1) cannot wrap for N near the top of the range.
    assign half       = ({1'b0, cur_n_i} + {{W{1'b0}}, 1'b1}) >> 1;
    assign cnt_inc    = cnt_q + W'(1);
    assign boundary_o = active_i && (cnt_q == cur_n_i - W'(1));

    always_comb begin
        cnt_d     = '0;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        if (start_i) begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
        end else if (active_i) begin
            if (boundary_o) begin
                // New period starts at cnt=0, which is always in the high phase.
                clk_out_d = restart_i;
                tick_d    = restart_i;
            end else begin
                cnt_d     = cnt_inc;
                clk_out_d = {1'b0, cnt_inc} < half;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the system clock divider. Holds the active ratio,
// accepts new ratios over a valid/ready channel and applies them only at a
// period boundary, and sequences start/stop with a drain to end of period.
// Ports:
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   en_i          - run request (level)
//   cfg           - ratio configuration channel (slave side)
//   clk_out_o     - divided clock, registered
//   tick_o        - one-cycle pulse at each divided rising edge
//   busy_o        - high in RUN or STOP
//   cur_n_o       - ratio currently in effect
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int unsigned W         = DIV_W,
    parameter int unsigned DEFAULT_N = 32'd67108864
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    clk_div_ctrl_if.slave cfg,
    output logic          clk_out_o,
    output logic          tick_o,
    output logic          busy_o,
    output logic [W-1:0]  cur_n_o
);

    state_e       state_q, state_d;
    logic [W-1:0] cur_n_q, cur_n_d;
    logic [W-1:0] pend_n_q, pend_n_d;
    logic         pend_valid_q, pend_valid_d;
    logic         cfg_err_q, cfg_err_d;
    logic         start, active, restart, boundary;
    logic         xfer, legal;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (en_i) state_d = StRun;
            StRun:  if (!en_i) state_d = StStop;
            StStop: begin
                if (en_i) begin
                    state_d = StRun;
                end else if (boundary) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        start   = (state_q == StIdle) && en_i;
        active  = (state_q == StRun) || (state_q == StStop);
        // RUN always continues into a new period; STOP continues only if re-enabled.
        restart = (state_q == StRun) || en_i;
        busy_o  = active;
    end

    // Ratio handshake and pending slot
    assign cfg.cfg_ready = !pend_valid_q;
    assign xfer          = cfg.cfg_valid && !pend_valid_q;
    assign legal         = cfg.cfg_n >= W'(DIV_MIN);

    always_comb begin
        cur_n_d      = cur_n_q;
        pend_n_d     = pend_n_q;
        pend_valid_d = pend_valid_q;
        cfg_err_d    = xfer && !legal;
        if (state_q == StIdle) begin
            // A ratio accepted in the final STOP boundary lands here in the slot.
            if (pend_valid_q) begin
                cur_n_d      = pend_n_q;
                pend_valid_d = 1'b0;
            end else if (xfer && legal) begin
                cur_n_d = cfg.cfg_n;
            end
        end else begin
            if (boundary && pend_valid_q) begin
                cur_n_d      = pend_n_q;
                pend_valid_d = 1'b0;
            end
            // Slot is empty whenever xfer is possible, so filling wins over clearing.
            if (xfer && legal) begin
                pend_n_d     = cfg.cfg_n;
                pend_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_n_q      <= W'(DEFAULT_N);
            pend_n_q     <= '0;
            pend_valid_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            cur_n_q      <= cur_n_d;
            pend_n_q     <= pend_n_d;
            pend_valid_q <= pend_valid_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign cfg.cfg_err = cfg_err_q;
    assign cur_n_o     = cur_n_q;

    clk_div_core #(
        .W (W)
    ) u_core (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start),
        .active_i   (active),
        .restart_i  (restart),
        .cur_n_i    (cur_n_q),
        .boundary_o (boundary),
        .clk_out_o  (clk_out_o),
        .tick_o     (tick_o)
    );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with DEFAULT_N=4. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        clk_out, tick, busy;
    logic [31:0] cur_n;
    int          n_assert = 0;
    int          n_fail = 0;

    clk_div_ctrl_if #(.W(32)) cfg_bus ();

    clk_div_ctrl #(
        .W         (32),
        .DEFAULT_N (4)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en),
        .cfg       (cfg_bus),
        .clk_out_o (clk_out),
        .tick_o    (tick),
        .busy_o    (busy),
        .cur_n_o   (cur_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks clk_out/tick for n consecutive cycles; bit i of each pattern is cycle i.
    task automatic wave(input string tag, input int n, input logic [31:0] clk_pat,
                        input logic [31:0] tick_pat);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s clk_out[%0d]", tag, i), {31'd0, clk_out}, {31'd0, clk_pat[i]});
            check($sformatf("%s tick[%0d]", tag, i), {31'd0, tick}, {31'd0, tick_pat[i]});
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cfg_bus.cfg_n = '0;
        cfg_bus.cfg_valid = 1'b0;

        // Reset values
        #12;
        check("rst clk_out", {31'd0, clk_out}, 32'd0);
        check("rst tick", {31'd0, tick}, 32'd0);
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst cur_n", cur_n, 32'd4);
        check("rst ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        check("rst err", {31'd0, cfg_bus.cfg_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default N=4: 1,1,0,0 repeating
        @(negedge clk);
        en = 1'b1;
        wave("n4", 8, 32'h33, 32'h11);
        check("n4 cur_n", cur_n, 32'd4);
        check("n4 busy", {31'd0, busy}, 32'd1);

        // N=5 accepted in IDLE: 1,1,1,0,0
        do_reset();
        cfg_bus.cfg_n = 32'd5;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("idle load cur_n", cur_n, 32'd5);
        check("idle busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        wave("n5", 10, 32'h0E7, 32'h021);

        // Illegal ratios 1 and 0
        cfg_bus.cfg_n = 32'd1;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge clk);
        check("err1 pulse", {31'd0, cfg_bus.cfg_err}, 32'd1);
        check("err1 cur_n", cur_n, 32'd5);
        check("err1 ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        check("err1 clk_out", {31'd0, clk_out}, 32'd1);
        check("err1 tick", {31'd0, tick}, 32'd1);
        cfg_bus.cfg_n = 32'd0;
        @(negedge clk);
        check("err0 pulse", {31'd0, cfg_bus.cfg_err}, 32'd1);
        check("err0 clk_out", {31'd0, clk_out}, 32'd1);
        cfg_bus.cfg_valid = 1'b0;
        @(negedge clk);
        check("err clear", {31'd0, cfg_bus.cfg_err}, 32'd0);
        check("err clk_out", {31'd0, clk_out}, 32'd1);
        check("err cur_n", cur_n, 32'd5);
        @(negedge clk);
        check("err low phase", {31'd0, clk_out}, 32'd0);

        // Running N=4, push N=2 at cnt=1
        do_reset();
        en = 1'b1;
        wave("pre2", 2, 32'h3, 32'h1);
        cfg_bus.cfg_n = 32'd2;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("pend ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        check("pend cur_n", cur_n, 32'd4);
        check("pend clk_out c2", {31'd0, clk_out}, 32'd0);
        @(negedge clk);
        check("pend ready c3", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        check("pend cur_n c3", cur_n, 32'd4);
        check("pend clk_out c3", {31'd0, clk_out}, 32'd0);
        @(negedge clk);
        check("n2 cur_n at boundary", cur_n, 32'd2);
        check("n2 ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        check("n2 clk_out[0]", {31'd0, clk_out}, 32'd1);
        check("n2 tick[0]", {31'd0, tick}, 32'd1);
        wave("n2", 3, 32'h2, 32'h2);

        // N=6, drop EN at cnt=2: drain then idle
        do_reset();
        cfg_bus.cfg_n = 32'd6;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("n6 cur_n", cur_n, 32'd6);
        en = 1'b1;
        wave("n6a", 3, 32'h7, 32'h1);
        en = 1'b0;
        wave("drain", 3, 32'h0, 32'h0);
        check("drain busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("stop clk_out", {31'd0, clk_out}, 32'd0);
        check("stop tick", {31'd0, tick}, 32'd0);
        check("stop busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("idle tick", {31'd0, tick}, 32'd0);
        check("idle busy", {31'd0, busy}, 32'd0);

        // Re-raise EN at cnt=4: no gap
        en = 1'b1;
        wave("n6b", 3, 32'h7, 32'h1);
        en = 1'b0;
        wave("n6b stop", 2, 32'h0, 32'h0);
        en = 1'b1;
        @(negedge clk);
        check("resume c5 clk_out", {31'd0, clk_out}, 32'd0);
        check("resume c5 busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("resume edge clk_out", {31'd0, clk_out}, 32'd1);
        check("resume edge tick", {31'd0, tick}, 32'd1);
        @(negedge clk);
        check("resume c1 clk_out", {31'd0, clk_out}, 32'd1);
        check("resume c1 tick", {31'd0, tick}, 32'd0);

        // Async reset mid-period with slot full
        cfg_bus.cfg_n = 32'd3;
        cfg_bus.cfg_valid = 1'b1;
        @(negedge clk);
        cfg_bus.cfg_valid = 1'b0;
        check("full ready", {31'd0, cfg_bus.cfg_ready}, 32'd0);
        check("full clk_out", {31'd0, clk_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst clk_out", {31'd0, clk_out}, 32'd0);
        check("arst tick", {31'd0, tick}, 32'd0);
        check("arst busy", {31'd0, busy}, 32'd0);
        check("arst cur_n", cur_n, 32'd4);
        check("arst ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        check("arst err", {31'd0, cfg_bus.cfg_err}, 32'd0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post rst ready", {31'd0, cfg_bus.cfg_ready}, 32'd1);
        check("post rst cur_n", cur_n, 32'd4);
        check("post rst clk_out", {31'd0, clk_out}, 32'd0);
        check("post rst busy", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
